// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - two-requester round-robin bit-serial shift sequencer
// One command in flight: accept in IDLE, shift one bit per cycle in SHIFT, hold result in DONE.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_dir,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_dir,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic [WIDTH-1:0] req1_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [AMT_W-1:0] cnt_q;
    logic             id_q;
    logic             ptr_q;

    logic             grant;
    logic             hs;
    logic             sel_dir;
    logic [AMT_W-1:0] sel_amt;
    logic [WIDTH-1:0] sel_data;

    // Round-robin pointer only matters when both requesters contend.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        req0_ready = (state == IDLE) && !RST && req0_valid && !grant;
        req1_ready = (state == IDLE) && !RST && req1_valid && grant;
        hs         = req0_ready || req1_ready;
        sel_dir    = grant ? req1_dir  : req0_dir;
        sel_amt    = grant ? req1_amt  : req0_amt;
        sel_data   = grant ? req1_data : req0_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nxt = (sel_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == AMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            data_q <= '0;
            dir_q  <= 1'b0;
            cnt_q  <= '0;
            id_q   <= 1'b0;
            ptr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (hs) begin
                        data_q <= sel_data;
                        dir_q  <= sel_dir;
                        cnt_q  <= sel_amt;
                        id_q   <= grant;
                        ptr_q  <= ~grant;
                    end
                end
                SHIFT: begin
                    // Logical shift: vacated bits fill with zero, shifted-out bits are lost.
                    data_q <= dir_q ? (data_q >> 1) : (data_q << 1);
                    cnt_q  <= cnt_q - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (state == DONE);
    assign res_data  = data_q;
    assign res_id    = id_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed and randomized self-checking bench for shift_sequencer
// Expected results come from a command-level model: result = data shifted by amt, latency = amt.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             req0_valid, req0_ready, req0_dir;
    logic [AMT_W-1:0] req0_amt;
    logic [WIDTH-1:0] req0_data;
    logic             req1_valid, req1_ready, req1_dir;
    logic [AMT_W-1:0] req1_amt;
    logic [WIDTH-1:0] req1_data;
    logic             res_valid, res_ready, res_id, busy;
    logic [WIDTH-1:0] res_data;

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_dir   (req0_dir),
        .req0_amt   (req0_amt),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_dir   (req1_dir),
        .req1_amt   (req1_amt),
        .req1_data  (req1_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int               nvec = 0;
    int               nerr = 0;
    bit               mptr;
    logic             c_dir  [2];
    logic [AMT_W-1:0] c_amt  [2];
    logic [WIDTH-1:0] c_data [2];
    logic [WIDTH-1:0] got_data;
    logic             got_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < 2; i++) begin
            c_dir[i]  = 1'($urandom_range(0, 1));
            c_amt[i]  = AMT_W'($urandom_range(0, 7));
            c_data[i] = WIDTH'($urandom);
        end
    endtask

    task automatic scramble_inputs();
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_dir   = 1'($urandom_range(0, 1));
        req1_dir   = 1'($urandom_range(0, 1));
        req0_amt   = AMT_W'($urandom);
        req1_amt   = AMT_W'($urandom);
        req0_data  = WIDTH'($urandom);
        req1_data  = WIDTH'($urandom);
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready  = 1'b0;
        step();
        #1;
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        step();
        RST        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, '0);
        check("rst_res_id", res_id, 1'b0);
        mptr = 1'b0;
    endtask

    // Issue a command from requester n (or both when contend=1) and follow it to retirement.
    task automatic do_cmd(input int n, input bit contend, input int hold, input bit scramble,
                          input bit keep_rr);
        int               g;
        int               cyc;
        logic [WIDTH-1:0] expd;
        req0_valid = (n == 0) || contend;
        req1_valid = (n == 1) || contend;
        req0_dir   = c_dir[0];
        req0_amt   = c_amt[0];
        req0_data  = c_data[0];
        req1_dir   = c_dir[1];
        req1_amt   = c_amt[1];
        req1_data  = c_data[1];
        res_ready  = keep_rr;
        #1;
        g = contend ? int'(mptr) : n;
        check("grant_ready0", req0_ready, g == 0);
        check("grant_ready1", req1_ready, g == 1);
        expd = c_dir[g] ? (c_data[g] >> c_amt[g]) : (c_data[g] << c_amt[g]);
        step();
        mptr = (g == 0);
        if (scramble) scramble_inputs();
        else begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        cyc = 0;
        while (cyc <= 20) begin
            #1;
            check("busy_ready0", req0_ready, 1'b0);
            check("busy_ready1", req1_ready, 1'b0);
            if (res_valid) break;
            check("busy_flag", busy, 1'b1);
            step();
            cyc++;
            if (scramble) scramble_inputs();
        end
        check("latency", cyc, c_amt[g]);
        check("res_data", res_data, expd);
        check("res_id", res_id, g);
        got_data = res_data;
        got_id   = res_id;
        if (!keep_rr) begin
            for (int h = 0; h < hold; h++) begin
                step();
                if (scramble) scramble_inputs();
                #1;
                check("hold_valid", res_valid, 1'b1);
                check("hold_data", res_data, expd);
                check("hold_id", res_id, g);
                check("hold_ready0", req0_ready, 1'b0);
                check("hold_ready1", req1_ready, 1'b0);
            end
        end
        res_ready = 1'b1;
        step();
        res_ready  = keep_rr;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("retire_valid", res_valid, 1'b0);
        check("retire_busy", busy, 1'b0);
    endtask

    initial begin
        RST = 1'b1;
        res_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_dir = 1'b0; req1_dir = 1'b0;
        req0_amt = '0; req1_amt = '0;
        req0_data = '0; req1_data = '0;
        do_reset();

        // Left shift by 3 from requester 0.
        rand_fields();
        c_dir[0] = 1'b0; c_amt[0] = 3'd3; c_data[0] = 8'h0B;
        do_cmd(0, 1'b0, 0, 1'b0, 1'b0);
        check("d1_data", got_data, 8'h58);
        check("d1_id", got_id, 1'b0);

        // Zero-amount pass-through from requester 1.
        c_dir[1] = 1'b1; c_amt[1] = 3'd0; c_data[1] = 8'hA5;
        do_cmd(1, 1'b0, 0, 1'b0, 1'b0);
        check("d2_data", got_data, 8'hA5);
        check("d2_id", got_id, 1'b1);

        // Contention with res_ready held high: grants alternate starting at requester 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            do_cmd(0, 1'b1, 0, 1'b0, 1'b1);
            check("alt_grant", got_id, i % 2);
        end
        res_ready = 1'b0;

        // Max right shift, result held for 5 cycles with inputs churning.
        c_dir[0] = 1'b1; c_amt[0] = 3'd7; c_data[0] = 8'hFF;
        do_cmd(0, 1'b0, 5, 1'b1, 1'b0);
        check("d4_data", got_data, 8'h01);

        // Reset two edges into a 5-step shift abandons the command and clears the pointer.
        rand_fields();
        c_amt[0] = 3'd5;
        req0_valid = 1'b1; req0_dir = c_dir[0]; req0_amt = c_amt[0]; req0_data = c_data[0];
        step();
        req0_valid = 1'b0;
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", res_valid, 1'b0);
        check("abort_data", res_data, '0);
        mptr = 1'b0;
        rand_fields();
        do_cmd(1, 1'b1, 0, 1'b0, 1'b0);
        check("abort_regrant", got_id, 1'b0);

        // Reset while the result is waiting in DONE.
        rand_fields();
        c_amt[1] = 3'd0;
        req1_valid = 1'b1; req1_dir = c_dir[1]; req1_amt = c_amt[1]; req1_data = c_data[1];
        step();
        req1_valid = 1'b0;
        #1;
        check("done_valid", res_valid, 1'b1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        check("done_abort_valid", res_valid, 1'b0);
        check("done_abort_busy", busy, 1'b0);
        check("done_abort_data", res_data, '0);
        mptr = 1'b0;

        // Randomized commands against the model.
        for (int i = 0; i < 40; i++) begin
            bit krr;
            rand_fields();
            krr = 1'($urandom_range(0, 1));
            do_cmd(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 1'b1, krr);
            res_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
